// File: rtl/count_pkg.sv
// Shared types and constants for the up/down count direction decoder.
// The state encoding and direction polarity live here so that every block agrees on them.
package count_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACQ   = 2'd1,
        S_TRACK = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage : count_pkg

// File: rtl/count_step_classify.sv
// Combinational classification of one count sample against the stored reference.
// It produces mutually exclusive up/down/hold/error flags, plus a wrap flag for steps that cross the max<->0 boundary.
module count_step_classify #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] cnt_in,
    input  logic [WIDTH-1:0] ref_val,
    output logic             is_up,
    output logic             is_down,
    output logic             is_hold,
    output logic             is_err,
    output logic             is_wrap
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;

    logic [WIDTH-1:0] diff;

    // Modular subtraction lets max->0 and 0->max read as single steps.
    assign diff    = cnt_in - ref_val;
    assign is_up   = (diff == ONE);
    assign is_down = (diff == ALL_ONES);
    assign is_hold = (diff == ZERO);
    assign is_err  = !(is_up || is_down || is_hold);
    assign is_wrap = (is_up && (cnt_in == ZERO)) || (is_down && (cnt_in == ALL_ONES));

endmodule : count_step_classify

// File: rtl/count_dir_decoder.sv
// Recovers the counting direction from a stream of observed up/down counter samples.
// All outputs are registered, and each accepted sample is answered one cycle after the edge that accepts it.
module count_dir_decoder
    import count_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_valid,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             dir_out,
    output logic             dir_valid,
    output logic             hold,
    output logic             step_err,
    output logic             wrap,
    output logic [RUN_W-1:0] run_len,
    output logic             locked
);

    localparam logic [RUN_W-1:0] RUN_MAX = '1;
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    state_t           state_reg;
    logic [WIDTH-1:0] ref_reg;
    logic             dir_reg;
    logic [RUN_W-1:0] run_reg;
    logic             dir_valid_reg;
    logic             hold_reg;
    logic             step_err_reg;
    logic             wrap_reg;

    logic is_up;
    logic is_down;
    logic is_hold;
    logic is_err;
    logic is_wrap;
    logic step_dir;

    count_step_classify #(
        .WIDTH (WIDTH)
    ) u_classify (
        .cnt_in  (cnt_in),
        .ref_val (ref_reg),
        .is_up   (is_up),
        .is_down (is_down),
        .is_hold (is_hold),
        .is_err  (is_err),
        .is_wrap (is_wrap)
    );

    assign step_dir = is_up ? DIR_UP : DIR_DOWN;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            ref_reg       <= '0;
            dir_reg       <= DIR_DOWN;
            run_reg       <= '0;
            dir_valid_reg <= 1'b0;
            hold_reg      <= 1'b0;
            step_err_reg  <= 1'b0;
            wrap_reg      <= 1'b0;
        end else begin
            // Pulses last exactly one cycle and fall back to zero whenever no sample arrives.
            dir_valid_reg <= 1'b0;
            hold_reg      <= 1'b0;
            step_err_reg  <= 1'b0;
            wrap_reg      <= 1'b0;
            if (cnt_valid) begin
                case (state_reg)
                    S_IDLE: begin
                        ref_reg   <= cnt_in;
                        state_reg <= S_ACQ;
                    end
                    S_ACQ, S_TRACK: begin
                        if (is_up || is_down) begin
                            dir_valid_reg <= 1'b1;
                            wrap_reg      <= is_wrap;
                            dir_reg       <= step_dir;
                            ref_reg       <= cnt_in;
                            state_reg     <= S_TRACK;
                            if (state_reg == S_ACQ || step_dir != dir_reg) begin
                                run_reg <= RUN_ONE;
                            end else if (run_reg != RUN_MAX) begin
                                run_reg <= run_reg + RUN_ONE;
                            end
                        end else if (is_hold) begin
                            hold_reg <= 1'b1;
                        end else if (is_err) begin
                            // Resynchronise on the bad sample but drop the lock and the run.
                            step_err_reg <= 1'b1;
                            ref_reg      <= cnt_in;
                            run_reg      <= '0;
                            state_reg    <= S_ACQ;
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign dir_out   = dir_reg;
    assign dir_valid = dir_valid_reg;
    assign hold      = hold_reg;
    assign step_err  = step_err_reg;
    assign wrap      = wrap_reg;
    assign run_len   = run_reg;
    assign locked    = (state_reg == S_TRACK);

endmodule : count_dir_decoder

// File: doc/count_dir_decoder.md
COUNT_DIR_DECODER -- requirements
Module: count_dir_decoder

Interface
REQ-001 Parameter WIDTH, default 3: width of the observed count bus.
REQ-002 Parameter RUN_W, default 8: width of the run-length output.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset is synchronous and active-low.
REQ-005 cnt_valid  in  1  cnt_in carries a sample this cycle.
REQ-006 cnt_in  in  WIDTH  observed up/down counter value.
REQ-007 dir_out  out  1  last recovered direction: 1 = up, 0 = down.
REQ-008 dir_valid  out  1  one-cycle pulse: a valid +/-1 step was decoded.
REQ-009 hold  out  1  one-cycle pulse: sample equal to previous reference.
REQ-010 step_err  out  1  one-cycle pulse: step was neither 0 nor +/-1 (mod 2^WIDTH).
REQ-011 wrap  out  1  one-cycle pulse: valid step crossed max<->0.
REQ-012 run_len  out  RUN_W  consecutive valid steps in the same direction, saturating.
REQ-013 locked  out  1  high while FSM is in S_TRACK.

Function
REQ-014 FSM states: S_IDLE (no reference), S_ACQ (reference held, direction unknown), S_TRACK (at least one valid step decoded).
REQ-015 Cycles with cnt_valid=0 change no state, no reference, no registered value; all pulse outputs are 0 the following cycle.
REQ-016 S_IDLE + cnt_valid: capture cnt_in as reference, go to S_ACQ, no pulses.
REQ-017 Step classification: diff = (cnt_in - ref) mod 2^WIDTH; diff==1 -> up; diff==2^WIDTH-1 -> down; diff==0 -> hold; otherwise -> error.
REQ-018 Up/down step (S_ACQ or S_TRACK): dir_valid=1, dir_out=step direction, reference=cnt_in, state=S_TRACK.
REQ-019 run_len: first step from S_ACQ -> 1; same direction as dir_out in S_TRACK -> run_len+1, saturating at 2^RUN_W-1; direction reversal -> 1.
REQ-020 wrap=1 on an up step with cnt_in==0 or a down step with cnt_in==2^WIDTH-1; wrap is only asserted together with dir_valid.
REQ-021 Hold: hold=1, state, dir_out, run_len unchanged.
REQ-022 Error: step_err=1, reference=cnt_in, run_len=0, dir_out retained, state=S_ACQ (locked=0).
REQ-023 All outputs are registered; the response to a sample appears exactly 1 cycle after the accepting edge.
REQ-024 At most one of dir_valid, hold, step_err is asserted in any cycle.

Reset
REQ-025 rst_n=0 sampled at a rising edge: state=S_IDLE, reference=0, dir_out=0, run_len=0, locked=0, all pulses 0.
REQ-026 Reset dominates cnt_valid; a sample presented in a reset cycle is discarded.
REQ-027 The first valid sample after reset produces no pulse (it only seeds the reference).

Structure
REQ-028 Shared package count_pkg holds the state enum typedef and constants DIR_UP=1, DIR_DOWN=0.
REQ-029 Step classification (REQ-017, wrap detection) is a combinational sub-module count_step_classify; FSM, reference and run_len registers remain in count_dir_decoder.

Verification (WIDTH=3, RUN_W=8 unless stated)
REQ-030 Reset, then samples 0,1,2,3 -> first sample no pulse; then dir_valid each step, dir_out=1, run_len 1,2,3, locked=1 after sample 1.
REQ-031 Samples 6,7,0,7,6 -> wrap with sample 0 (dir_out=1, run_len=2); at sample 7 dir_out=0, run_len=1, wrap=1; at 6 run_len=2, wrap=0.
REQ-032 Samples 2,3,6,7 -> step_err at 6, locked=0, run_len=0, dir_out=1 retained; at 7 dir_valid, run_len=1, locked=1.
REQ-033 Samples 4,4 with cnt_valid=0 gaps between them -> hold pulse only at second 4; no pulses in gap cycles; run_len unchanged.
REQ-034 RUN_W=2, 5 consecutive up steps -> run_len 1,2,3,3,3 (saturation).
REQ-035 rst_n=0 for one cycle mid-run with cnt_valid=1 -> next cycle all outputs 0, locked=0; next sample seeds only, second sample gives dir_valid, run_len=1.
